// File: rtl/cpu_pkg.sv
// Shared Mini SRC definitions: opcodes, ALU operation codes, control-sequencer
// state encoding and the instruction classes produced by op_decode.
package cpu_pkg;

    localparam int OPCODE_W = 5;
    localparam int ALU_W    = 5;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00001;
    localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00010;
    localparam logic [ALU_W-1:0] ALU_AND  = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_OR   = 5'b00100;

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_RFMT, CLS_IMM, CLS_LD, CLS_ST, CLS_BR, CLS_NOP, CLS_HALT
    } op_class_t;

endpackage

// File: rtl/op_decode.sv
// Opcode classifier: maps IR[31:27] onto an instruction class and the ALU code
// that class uses; undefined opcodes behave as nop.
module op_decode
    import cpu_pkg::*;
#(
    parameter int OPW  = OPCODE_W,
    parameter int ALUW = ALU_W
) (
    input  logic [OPW-1:0]  opcode,
    output op_class_t       op_class,
    output logic [ALUW-1:0] alu_op
);

    always_comb begin
        op_class = CLS_NOP;
        alu_op   = ALUW'(ALU_ADD);
        case (opcode)
            OP_ADD:  begin op_class = CLS_RFMT; alu_op = ALUW'(ALU_ADD); end
            OP_SUB:  begin op_class = CLS_RFMT; alu_op = ALUW'(ALU_SUB); end
            OP_AND:  begin op_class = CLS_RFMT; alu_op = ALUW'(ALU_AND); end
            OP_OR:   begin op_class = CLS_RFMT; alu_op = ALUW'(ALU_OR);  end
            OP_ADDI: begin op_class = CLS_IMM;  alu_op = ALUW'(ALU_ADD); end
            OP_ANDI: begin op_class = CLS_IMM;  alu_op = ALUW'(ALU_AND); end
            OP_ORI:  begin op_class = CLS_IMM;  alu_op = ALUW'(ALU_OR);  end
            OP_LD:   op_class = CLS_LD;
            OP_ST:   op_class = CLS_ST;
            OP_BR:   op_class = CLS_BR;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC control sequencer: steps through T-states per instruction
// and decodes state plus opcode into the DataPath enables and selects.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     ir,
    input  logic            con,
    input  logic            stop,
    output logic            run,
    output logic            Pout,
    output logic            MARen,
    output logic            Read,
    output logic            MDRen,
    output logic            MDROut,
    output logic            IRen,
    output logic            IncPC,
    output logic            Pen,
    output logic            Write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            ConIn,
    output logic            Yen,
    output logic            Zen,
    output logic            ZLOout,
    output logic            Cout,
    output logic [ALUW-1:0] alu_control
);

    state_t          state;
    state_t          end_next;
    logic            started;
    op_class_t       op_class;
    logic [ALUW-1:0] alu_op;
    logic            unused_ir;

    assign unused_ir = ^ir[31-OPW:0];
    assign end_next  = stop ? HALT : T0;

    op_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
        .opcode   (ir[31 -: OPW]),
        .op_class (op_class),
        .alu_op   (alu_op)
    );

    // IDLE lingers one extra edge after reset release so the first T0 lands on
    // the second rising edge, giving the datapath a clean cycle out of reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    started <= 1'b1;
                    if (started) state <= T0;
                end
                T0: state <= T1;
                T1: state <= T2;
                T2: state <= (op_class == CLS_NOP) ? end_next : T3;
                T3: begin
                    if (op_class == CLS_HALT)     state <= HALT;
                    else if (op_class == CLS_NOP) state <= end_next;
                    else                          state <= T4;
                end
                T4: state <= T5;
                T5: state <= (op_class inside {CLS_LD, CLS_ST, CLS_BR}) ? T6 : end_next;
                T6: state <= (op_class inside {CLS_LD, CLS_ST}) ? T7 : end_next;
                T7: state <= end_next;
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        run = (state != IDLE) && (state != HALT);
        Pout = 1'b0; MARen = 1'b0; Read = 1'b0; MDRen = 1'b0; MDROut = 1'b0;
        IRen = 1'b0; IncPC = 1'b0; Pen = 1'b0; Write = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; ConIn = 1'b0;
        Yen = 1'b0; Zen = 1'b0; ZLOout = 1'b0; Cout = 1'b0;
        alu_control = ALUW'(ALU_NONE);
        case (state)
            T0: begin Pout = 1'b1; MARen = 1'b1; IncPC = 1'b1; Zen = 1'b1; end
            T1: begin ZLOout = 1'b1; Pen = 1'b1; Read = 1'b1; MDRen = 1'b1; end
            T2: begin MDROut = 1'b1; IRen = 1'b1; end
            T3: case (op_class)
                CLS_RFMT, CLS_IMM: begin Grb = 1'b1; Rout = 1'b1; Yen = 1'b1; end
                CLS_LD, CLS_ST:    begin Grb = 1'b1; BAout = 1'b1; Yen = 1'b1; end
                CLS_BR:            begin Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1; end
                default: ;
            endcase
            T4: case (op_class)
                CLS_RFMT: begin Grc = 1'b1; Rout = 1'b1; Zen = 1'b1; alu_control = alu_op; end
                CLS_IMM:  begin Cout = 1'b1; Zen = 1'b1; alu_control = alu_op; end
                CLS_LD, CLS_ST: begin Cout = 1'b1; Zen = 1'b1; alu_control = ALUW'(ALU_ADD); end
                CLS_BR:   begin Pout = 1'b1; Yen = 1'b1; end
                default: ;
            endcase
            T5: case (op_class)
                CLS_RFMT, CLS_IMM: begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CLS_LD, CLS_ST:    begin ZLOout = 1'b1; MARen = 1'b1; end
                CLS_BR: begin Cout = 1'b1; Zen = 1'b1; alu_control = ALUW'(ALU_ADD); end
                default: ;
            endcase
            T6: case (op_class)
                CLS_LD: begin Read = 1'b1; MDRen = 1'b1; end
                CLS_ST: begin Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1; end
                CLS_BR: begin ZLOout = con; Pen = con; end
                default: ;
            endcase
            T7: case (op_class)
                CLS_LD: begin MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                CLS_ST: Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-cycle vector table feeding a scoreboard queue,
// plus hand-built reset, stop and halt sequences.
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        con;
    logic        stop;
    logic        run, Pout, MARen, Read, MDRen, MDROut, IRen, IncPC, Pen, Write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, ConIn, Yen, Zen, ZLOout, Cout;
    logic [4:0]  alu_control;

    control_unit #(.OPW(5), .ALUW(5)) dut (
        .clk(clk), .clr(clr), .ir(ir), .con(con), .stop(stop), .run(run),
        .Pout(Pout), .MARen(MARen), .Read(Read), .MDRen(MDRen), .MDROut(MDROut),
        .IRen(IRen), .IncPC(IncPC), .Pen(Pen), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .ConIn(ConIn), .Yen(Yen), .Zen(Zen), .ZLOout(ZLOout), .Cout(Cout),
        .alu_control(alu_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [25:0] RUN   = 26'd1 << 25;
    localparam logic [25:0] POUT  = 26'd1 << 24;
    localparam logic [25:0] MARE  = 26'd1 << 23;
    localparam logic [25:0] READ  = 26'd1 << 22;
    localparam logic [25:0] MDRE  = 26'd1 << 21;
    localparam logic [25:0] MDRO  = 26'd1 << 20;
    localparam logic [25:0] IREN  = 26'd1 << 19;
    localparam logic [25:0] INCPC = 26'd1 << 18;
    localparam logic [25:0] PEN   = 26'd1 << 17;
    localparam logic [25:0] WRITE = 26'd1 << 16;
    localparam logic [25:0] GRA   = 26'd1 << 15;
    localparam logic [25:0] GRB   = 26'd1 << 14;
    localparam logic [25:0] GRC   = 26'd1 << 13;
    localparam logic [25:0] RIN   = 26'd1 << 12;
    localparam logic [25:0] ROUT  = 26'd1 << 11;
    localparam logic [25:0] BAOUT = 26'd1 << 10;
    localparam logic [25:0] CONIN = 26'd1 << 9;
    localparam logic [25:0] YEN   = 26'd1 << 8;
    localparam logic [25:0] ZEN   = 26'd1 << 7;
    localparam logic [25:0] ZLO   = 26'd1 << 6;
    localparam logic [25:0] COUT  = 26'd1 << 5;
    localparam logic [25:0] A_ADD = 26'd1;
    localparam logic [25:0] A_SUB = 26'd2;
    localparam logic [25:0] A_AND = 26'd3;
    localparam logic [25:0] A_OR  = 26'd4;

    typedef struct {
        string       tag;
        logic [31:0] ir;
        logic        con;
        logic        stop;
        logic [25:0] exp;
    } row_t;

    row_t        rows[$];
    logic [25:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [25:0] actual();
        return {run, Pout, MARen, Read, MDRen, MDROut, IRen, IncPC, Pen, Write,
                Gra, Grb, Grc, Rin, Rout, BAout, ConIn, Yen, Zen, ZLOout, Cout,
                alu_control};
    endfunction

    function automatic void add_row(string tag, logic [31:0] ir_v, logic con_v,
                                    logic stop_v, logic [25:0] e);
        row_t r;
        r.tag = tag; r.ir = ir_v; r.con = con_v; r.stop = stop_v; r.exp = e;
        rows.push_back(r);
    endfunction

    function automatic void add_fetch(string tag, logic [31:0] ir_v);
        add_row({tag, "_T0"}, ir_v, 1'b0, 1'b0, RUN | POUT | MARE | INCPC | ZEN);
        add_row({tag, "_T1"}, ir_v, 1'b0, 1'b0, RUN | ZLO | PEN | READ | MDRE);
        add_row({tag, "_T2"}, ir_v, 1'b0, 1'b0, RUN | MDRO | IREN);
    endfunction

    function automatic void add_rfmt(string tag, logic [31:0] ir_v, logic [25:0] alu, logic st);
        add_fetch(tag, ir_v);
        add_row({tag, "_T3"}, ir_v, 1'b0, st, RUN | GRB | ROUT | YEN);
        add_row({tag, "_T4"}, ir_v, 1'b0, st, RUN | GRC | ROUT | ZEN | alu);
        add_row({tag, "_T5"}, ir_v, 1'b0, st, RUN | ZLO | GRA | RIN);
    endfunction

    function automatic void add_imm(string tag, logic [31:0] ir_v, logic [25:0] alu);
        add_fetch(tag, ir_v);
        add_row({tag, "_T3"}, ir_v, 1'b0, 1'b0, RUN | GRB | ROUT | YEN);
        add_row({tag, "_T4"}, ir_v, 1'b0, 1'b0, RUN | COUT | ZEN | alu);
        add_row({tag, "_T5"}, ir_v, 1'b0, 1'b0, RUN | ZLO | GRA | RIN);
    endfunction

    function automatic void add_mem(string tag, logic [31:0] ir_v, logic is_st);
        add_fetch(tag, ir_v);
        add_row({tag, "_T3"}, ir_v, 1'b0, 1'b0, RUN | GRB | BAOUT | YEN);
        add_row({tag, "_T4"}, ir_v, 1'b0, 1'b0, RUN | COUT | ZEN | A_ADD);
        add_row({tag, "_T5"}, ir_v, 1'b0, 1'b0, RUN | ZLO | MARE);
        add_row({tag, "_T6"}, ir_v, 1'b0, 1'b0, is_st ? (RUN | GRA | ROUT | MDRE) : (RUN | READ | MDRE));
        add_row({tag, "_T7"}, ir_v, 1'b0, 1'b0, is_st ? (RUN | WRITE) : (RUN | MDRO | GRA | RIN));
    endfunction

    function automatic void add_br(string tag, logic [31:0] ir_v, logic con_v);
        add_fetch(tag, ir_v);
        add_row({tag, "_T3"}, ir_v, 1'b0, 1'b0, RUN | GRA | ROUT | CONIN);
        add_row({tag, "_T4"}, ir_v, 1'b0, 1'b0, RUN | POUT | YEN);
        add_row({tag, "_T5"}, ir_v, 1'b0, 1'b0, RUN | COUT | ZEN | A_ADD);
        add_row({tag, "_T6"}, ir_v, con_v, 1'b0, con_v ? (RUN | ZLO | PEN) : RUN);
    endfunction

    task automatic applyStimulus(input row_t r);
        ir   = r.ir;
        con  = r.con;
        stop = r.stop;
        exp_q.push_back(r.exp);
        tag_q.push_back(r.tag);
    endtask

    task automatic checkOutput();
        logic [25:0] e;
        string       t;
        logic [25:0] a;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, need one");
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = actual();
            total++;
            if (a !== e) begin
                bad++;
                $display("[TB] FAIL %s: controls got %h want %h", t, a, e);
            end
        end
    endtask

    task automatic run_table();
        for (int i = 0; i < rows.size(); i++) begin
            @(negedge clk);
            applyStimulus(rows[i]);
            #2;
            checkOutput();
        end
        rows.delete();
    endtask

    task automatic reset_now(input string tag);
        row_t r;
        r.tag = {tag, "_async"}; r.ir = ir; r.con = con; r.stop = stop; r.exp = 26'd0;
        clr = 1'b0;
        applyStimulus(r);
        #1;
        checkOutput();
        @(negedge clk);
        clr = 1'b1;
        r.tag = {tag, "_release"};
        applyStimulus(r);
        #2;
        checkOutput();
    endtask

    initial begin
        clr = 1'b1; ir = 32'h0; con = 1'b0; stop = 1'b0;
        #3;
        reset_now("reset0");

        add_row("idle", 32'h0, 1'b0, 1'b0, 26'd0);
        add_imm("andi", 32'h69180025, A_AND);
        add_rfmt("add", 32'h18A30000, A_ADD, 1'b0);
        add_rfmt("sub", 32'h20A30000, A_SUB, 1'b0);
        add_rfmt("and", 32'h28A30000, A_AND, 1'b0);
        add_rfmt("or",  32'h30A30000, A_OR,  1'b0);
        add_imm("addi", 32'h60800007, A_ADD);
        add_imm("ori",  32'h70800007, A_OR);
        add_mem("ld",   32'h00800010, 1'b0);
        add_mem("st",   32'h10800010, 1'b1);
        add_br("br_con0", 32'h90800004, 1'b0);
        add_br("br_con1", 32'h90800004, 1'b1);
        add_fetch("nop", 32'hD0000000);
        add_fetch("undef", 32'hF8000000);
        add_rfmt("add_stop", 32'h18A30000, A_ADD, 1'b1);
        for (int i = 0; i < 3; i++) add_row("stop_halt", 32'h18A30000, 1'b0, 1'b0, 26'd0);
        run_table();

        reset_now("reset1");
        add_row("idle1", 32'h18A30000, 1'b0, 1'b0, 26'd0);
        add_fetch("add_pre", 32'h18A30000);
        add_row("add_pre_T3", 32'h18A30000, 1'b0, 1'b0, RUN | GRB | ROUT | YEN);
        add_row("add_pre_T4", 32'h18A30000, 1'b0, 1'b0, RUN | GRC | ROUT | ZEN | A_ADD);
        run_table();

        reset_now("reset_midT4");
        add_row("idle2", 32'hD8000000, 1'b0, 1'b0, 26'd0);
        add_fetch("halt", 32'hD8000000);
        add_row("halt_T3", 32'hD8000000, 1'b0, 1'b0, RUN);
        for (int i = 0; i < 20; i++) add_row("halt_hold", 32'h18A30000, 1'b1, 1'b0, 26'd0);
        run_table();

        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL scoreboard_left: got %0d pending, need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
